// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op-code map, FSM states, status flags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   OP_* localparams  5-bit operation codes
//   state_t           FSM states of the iterative datapath
//   alu_flags_t       status bits that travel together with a result
//   is_multicycle()   true for the ops that run through the iterative units
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_XOR = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_SHL = 5'd9;
  localparam logic [4:0] OP_SRA = 5'd10;
  localparam logic [4:0] OP_EQ  = 5'd11;
  localparam logic [4:0] OP_NE  = 5'd12;
  localparam logic [4:0] OP_GE  = 5'd13;
  localparam logic [4:0] OP_GT  = 5'd14;
  localparam logic [4:0] OP_LE  = 5'd15;
  localparam logic [4:0] OP_LT  = 5'd16;
  localparam logic [4:0] OP_NOP = 5'd17;
  localparam logic [4:0] OP_IMM = 5'd18;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  typedef struct packed {
    logic is_true;
    logic overflow;
    logic div_zero;
  } alu_flags_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per step, on operand magnitudes.
// Latency: the load edge performs the first step; WIDTH-1 further steps finish it.
// Backpressure: none; the caller owns sequencing via load/step.
//
// Ports:
//   clk                  datapath clock, state updates on the falling edge
//   load                 capture dividend/divisor and perform the first step
//   dividend, divisor    unsigned magnitudes
//   step                 perform one more restoring step
//   quotient, remainder  valid after WIDTH total steps
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial, trial_diff;
  logic             fits;

  // The step logic reads fresh operands on the load edge, so loading also
  // retires the first quotient bit and the caller's counter stays at WIDTH.
  always_comb begin
    rem_src    = load ? '0 : rem_q;
    quo_src    = load ? dividend : quo_q;
    dvs_src    = load ? divisor : dvs_q;
    trial      = {rem_src, quo_src[WIDTH-1]};
    trial_diff = trial - {1'b0, dvs_src};
    fits       = (trial >= {1'b0, dvs_src});
    // Partial remainder stays below the divisor, so WIDTH bits always hold it.
    rem_nxt    = fits ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt    = {quo_src[WIDTH-2:0], fits};
  end

  always_ff @(negedge clk) begin
    if (load) begin
      dvs_q <= divisor;
    end
    if (load || step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/multicycle_alu.sv
// Signed ALU with iterative MUL (shift-add) and DIV/MOD (restoring) units.
// Latency: 1 edge for single-cycle ops and divide-by-zero, WIDTH+1 edges for MUL/DIV/MOD.
// Backpressure: Busy high while iterating; Start is ignored until Busy drops.
//
// Ports:
//   Fast_Clock   clock; all state changes on the falling edge
//   Reset        synchronous active-high reset, wins over Start
//   Start        request, sampled while Busy = 0, together with ALU_Op/Data_1/Data_2
//   Busy         iterative op in progress
//   Done         one-cycle pulse when Result/True/Overflow/Div_Zero are updated
//   Result/True/Overflow/Div_Zero  held until the next Done
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             Fast_Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       ALU_Op,
  input  logic [WIDTH-1:0] Data_1,
  input  logic [WIDTH-1:0] Data_2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             True,
  output logic             Overflow,
  output logic             Div_Zero
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_q;
  logic             neg_a_q;      // Data_1 was negative: sign of the remainder
  logic             neg_res_q;    // operand signs differ: sign of product/quotient
  logic             min_neg1_q;   // MIN / -1, the one quotient that cannot be represented

  logic             start_acc;
  logic             div_by_zero;
  logic             mc_load;
  logic             iter_step;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the ports on the accept edge
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]        sum, diff;
  logic [SHIFT_W-1:0]      shamt;
  logic [WIDTH-1:0]        sc_result;
  alu_flags_t              sc_flags;

  assign sa    = Data_1;
  assign sb    = Data_2;
  assign sum   = Data_1 + Data_2;
  assign diff  = Data_1 - Data_2;
  assign shamt = Data_2[SHIFT_W-1:0];

  always_comb begin
    sc_result = '0;
    sc_flags  = '0;
    case (ALU_Op)
      OP_ADD: begin
        sc_result         = sum;
        sc_flags.overflow = (Data_1[WIDTH-1] == Data_2[WIDTH-1]) &&
                            (sum[WIDTH-1] != Data_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result         = diff;
        sc_flags.overflow = (Data_1[WIDTH-1] != Data_2[WIDTH-1]) &&
                            (diff[WIDTH-1] != Data_1[WIDTH-1]);
      end
      // DIV/MOD only take this path when the divisor is zero.
      OP_DIV: begin
        sc_result         = '1;
        sc_flags.div_zero = 1'b1;
      end
      OP_MOD: begin
        sc_result         = Data_1;
        sc_flags.div_zero = 1'b1;
      end
      OP_AND: sc_result = Data_1 & Data_2;
      OP_OR:  sc_result = Data_1 | Data_2;
      OP_XOR: sc_result = Data_1 ^ Data_2;
      OP_NOT: sc_result = ~Data_1;
      OP_SHL: sc_result = Data_1 << shamt;
      OP_SRA: sc_result = sa >>> shamt;
      OP_EQ:  sc_flags.is_true = (sa == sb);
      OP_NE:  sc_flags.is_true = (sa != sb);
      OP_GE:  sc_flags.is_true = (sa >= sb);
      OP_GT:  sc_flags.is_true = (sa >  sb);
      OP_LE:  sc_flags.is_true = (sa <= sb);
      OP_LT:  sc_flags.is_true = (sa <  sb);
      OP_IMM: sc_result = Data_2;
      default: sc_result = '0;  // NOP and unused codes
    endcase
    if (sc_flags.is_true) begin
      sc_result = {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign start_acc   = Start && (state == IDLE);
  assign div_by_zero = ((ALU_Op == OP_DIV) || (ALU_Op == OP_MOD)) && (Data_2 == '0);
  assign mc_load     = start_acc && is_multicycle(ALU_Op) && !div_by_zero;
  // The load edge already performs the first step, so the final counter
  // value (1) is the edge that only publishes the result.
  assign iter_step   = (state == ITER) && (cnt != CNT_ONE);

  // ---------------------------------------------------------------------------
  // Iterative units, both fed with operand magnitudes
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mcand_q, mcand_src;
  logic [2*WIDTH-1:0] prod_q, prod_src, prod_nxt;
  logic [WIDTH:0]     part;
  logic [WIDTH-1:0]   quotient, remainder;

  // -MIN wraps to MIN, which read unsigned is exactly its magnitude.
  assign mag_a = Data_1[WIDTH-1] ? -Data_1 : Data_1;
  assign mag_b = Data_2[WIDTH-1] ? -Data_2 : Data_2;

  // Right-shifting shift-add: upper half accumulates, lower half starts as the
  // multiplier and is consumed one bit per step. A WIDTH-bit adder suffices.
  always_comb begin
    prod_src  = mc_load ? {{WIDTH{1'b0}}, mag_b} : prod_q;
    mcand_src = mc_load ? mag_a : mcand_q;
    part      = {1'b0, prod_src[2*WIDTH-1:WIDTH]} +
                (prod_src[0] ? {1'b0, mcand_src} : {(WIDTH+1){1'b0}});
    prod_nxt  = {part, prod_src[WIDTH-1:1]};
  end

  always_ff @(negedge Fast_Clock) begin
    if (mc_load) begin
      mcand_q <= mag_a;
    end
    if (mc_load || iter_step) begin
      prod_q <= prod_nxt;
    end
  end

  seq_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (Fast_Clock),
    .load      (mc_load),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .step      (iter_step),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Sign fix-up of the magnitude results.
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   mc_result;
  logic               mc_ovf;

  assign prod_signed = neg_res_q ? -prod_q : prod_q;
  assign quo_signed  = neg_res_q ? -quotient : quotient;
  assign rem_signed  = neg_a_q ? -remainder : remainder;
  // Product fits in WIDTH signed bits iff its top WIDTH+1 bits are all equal.
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];

  always_comb begin
    mc_result = '0;
    mc_ovf    = 1'b0;
    case (op_q)
      OP_MUL: begin
        mc_result = prod_signed[WIDTH-1:0];
        mc_ovf    = !((&prod_top) || !(|prod_top));
      end
      OP_DIV: begin
        mc_result = quo_signed;
        mc_ovf    = min_neg1_q;
      end
      default: mc_result = rem_signed;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(negedge Fast_Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= OP_NOP;
      neg_a_q    <= 1'b0;
      neg_res_q  <= 1'b0;
      min_neg1_q <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Result     <= '0;
      True       <= 1'b0;
      Overflow   <= 1'b0;
      Div_Zero   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (mc_load) begin
            state      <= ITER;
            cnt        <= CNT_LOAD;
            Busy       <= 1'b1;
            op_q       <= ALU_Op;
            neg_a_q    <= Data_1[WIDTH-1];
            neg_res_q  <= Data_1[WIDTH-1] ^ Data_2[WIDTH-1];
            min_neg1_q <= (Data_1 == MIN_VAL) && (Data_2 == '1);
          end else if (start_acc) begin
            Done     <= 1'b1;
            Result   <= sc_result;
            True     <= sc_flags.is_true;
            Overflow <= sc_flags.overflow;
            Div_Zero <= sc_flags.div_zero;
          end
        end
        ITER: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Result   <= mc_result;
            True     <= 1'b0;
            Overflow <= mc_ovf;
            Div_Zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 and WIDTH=8.
// Inputs are driven and outputs sampled on the rising edge; the DUT acts on the falling edge.
// Latency is counted in falling edges from the cycle Start is presented.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;

  logic        s32, busy32, done32, tr32, ov32, dz32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        s8, busy8, done8, tr8, ov8, dz8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, res8;

  int n_checks;
  int n_fail;
  int lat;
  int busy_n;
  int done_n;

  multicycle_alu #(.WIDTH(32)) dut32 (
    .Fast_Clock (clk),
    .Reset      (rst),
    .Start      (s32),
    .ALU_Op     (op32),
    .Data_1     (a32),
    .Data_2     (b32),
    .Busy       (busy32),
    .Done       (done32),
    .Result     (res32),
    .True       (tr32),
    .Overflow   (ov32),
    .Div_Zero   (dz32)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .Fast_Clock (clk),
    .Reset      (rst),
    .Start      (s8),
    .ALU_Op     (op8),
    .Data_1     (a8),
    .Data_2     (b8),
    .Busy       (busy8),
    .Done       (done8),
    .Result     (res8),
    .True       (tr8),
    .Overflow   (ov8),
    .Div_Zero   (dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, drop Start and scramble operands after the accept edge,
  // then wait (bounded) for Done. lat = 0 means Done never came.
  task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int l, output int bn);
    bit dn;
    bit bs;
    @(posedge clk);
    if (w8) begin
      s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    l  = 0;
    bn = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      dn = w8 ? done8 : done32;
      bs = w8 ? busy8 : busy32;
      if (i == 1) begin
        s8 = 1'b0; s32 = 1'b0;
        a32 = 32'hDEAD_BEEF; b32 = '0; a8 = 8'h5A; b8 = '0;
      end
      if (bs) bn++;
      if (dn) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    s32 = 1'b0; op32 = OP_NOP; a32 = '0; b32 = '0;
    s8  = 1'b0; op8  = OP_NOP; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    check_val("rst_result", res32, 32'h0);
    check_val("rst_flags", {busy32, done32, tr32, ov32, dz32}, 5'b0);
    rst = 1'b0;

    // ADD positive overflow
    run_op(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, busy_n);
    check_val("add_lat", lat, 1);
    check_val("add_busy", busy_n, 0);
    check_val("add_res", res32, 32'h8000_0000);
    check_val("add_ovf", ov32, 1'b1);
    check_val("add_true", tr32, 1'b0);
    @(posedge clk);
    check_val("add_done_pulse", done32, 1'b0);
    check_val("add_hold", res32, 32'h8000_0000);

    // SUB negative overflow
    run_op(1'b0, OP_SUB, 32'h8000_0000, 32'h1, lat, busy_n);
    check_val("sub_res", res32, 32'h7FFF_FFFF);
    check_val("sub_ovf", ov32, 1'b1);

    // MUL -7 * 6
    run_op(1'b0, OP_MUL, -32'sd7, 32'd6, lat, busy_n);
    check_val("mul_lat", lat, 33);
    check_val("mul_busy", busy_n, 32);
    check_val("mul_res", res32, 32'hFFFF_FFD6);
    check_val("mul_ovf", ov32, 1'b0);

    // MUL 2^16 * 2^16 overflows
    run_op(1'b0, OP_MUL, 32'h1_0000, 32'h1_0000, lat, busy_n);
    check_val("mul_big_res", res32, 32'h0);
    check_val("mul_big_ovf", ov32, 1'b1);

    // DIV / MOD signs
    run_op(1'b0, OP_DIV, -32'sd17, 32'd5, lat, busy_n);
    check_val("div_lat", lat, 33);
    check_val("div_res", res32, 32'hFFFF_FFFD);
    check_val("div_ovf", ov32, 1'b0);
    run_op(1'b0, OP_MOD, -32'sd17, 32'd5, lat, busy_n);
    check_val("mod_res", res32, 32'hFFFF_FFFE);

    // MIN / -1
    run_op(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
    check_val("div_min_res", res32, 32'h8000_0000);
    check_val("div_min_ovf", ov32, 1'b1);
    run_op(1'b0, OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
    check_val("mod_min_res", res32, 32'h0);
    check_val("mod_min_ovf", ov32, 1'b0);

    // Divide by zero completes at once
    run_op(1'b0, OP_DIV, 32'd9, 32'd0, lat, busy_n);
    check_val("dz_div_lat", lat, 1);
    check_val("dz_div_busy", busy_n, 0);
    check_val("dz_div_res", res32, 32'hFFFF_FFFF);
    check_val("dz_div_flag", dz32, 1'b1);
    run_op(1'b0, OP_MOD, 32'd9, 32'd0, lat, busy_n);
    check_val("dz_mod_res", res32, 32'd9);
    check_val("dz_mod_flag", dz32, 1'b1);

    // MUL aborted by Reset at iteration 10; an ADD during Busy is ignored
    done_n = 0;
    @(posedge clk);
    s32 = 1'b1; op32 = OP_MUL; a32 = 32'd3; b32 = 32'd4;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      if (done32) done_n++;
      if (i == 5) check_val("abort_busy", busy32, 1'b1);
      if (i == 1) s32 = 1'b0;
      if (i == 3) begin
        s32 = 1'b1; op32 = OP_ADD; a32 = 32'd2; b32 = 32'd3;
      end
      if (i == 4) s32 = 1'b0;
      if (i == 10) rst = 1'b1;
      if (i == 11) rst = 1'b0;
    end
    check_val("abort_no_done", done_n, 0);
    check_val("abort_res", res32, 32'h0);
    check_val("abort_flags", {busy32, done32, tr32, ov32, dz32}, 5'b0);

    run_op(1'b0, OP_ADD, 32'd2, 32'd3, lat, busy_n);
    check_val("add_after_lat", lat, 1);
    check_val("add_after_res", res32, 32'd5);

    // WIDTH = 8
    run_op(1'b1, OP_LT, 32'h0000_00FF, 32'h0000_0001, lat, busy_n);
    check_val("w8_lt_lat", lat, 1);
    check_val("w8_lt_res", res8, 8'h01);
    check_val("w8_lt_true", tr8, 1'b1);
    run_op(1'b1, OP_GT, 32'h0000_00FF, 32'h0000_0001, lat, busy_n);
    check_val("w8_gt_res", res8, 8'h00);
    check_val("w8_gt_true", tr8, 1'b0);
    run_op(1'b1, OP_SRA, 32'h0000_0080, 32'h0000_000B, lat, busy_n);
    check_val("w8_sra_res", res8, 8'hF0);
    check_val("w8_sra_true", tr8, 1'b0);
    run_op(1'b1, OP_MUL, 32'h0000_00F8, 32'h0000_0010, lat, busy_n);
    check_val("w8_mul_lat", lat, 9);
    check_val("w8_mul_res", res8, 8'h80);
    check_val("w8_mul_ovf", ov8, 1'b0);

    // Back-to-back EQ: second Start presented in the first Done cycle
    @(posedge clk);
    s8 = 1'b1; op8 = OP_EQ; a8 = 8'h33; b8 = 8'h33;
    @(posedge clk);
    check_val("b2b_done1", done8, 1'b1);
    check_val("b2b_res1", {res8, tr8}, {8'h01, 1'b1});
    b8 = 8'h34;
    @(posedge clk);
    check_val("b2b_done2", done8, 1'b1);
    check_val("b2b_res2", {res8, tr8}, {8'h00, 1'b0});
    s8 = 1'b0;
    @(posedge clk);
    check_val("b2b_done_end", done8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, multi-cycle successor to the processor's single-cycle ALU. It keeps the same 5-bit operation encoding and result/True semantics. Multiply, divide and modulo become iterative shift-add and restoring units, so the datapath closes timing at any `WIDTH`. A Start/Busy/Done handshake lets the control unit stall on long operations. It also adds Overflow and Div_Zero status flags, which the previous ALU lacked.

## Interface
- `WIDTH`, default 32: operand/result width, ≥ 4, power of two.
- `SHIFT_W`, default `$clog2(WIDTH)`: derived; shift-amount bits taken from Data_2.
- `Fast_Clock`  in  1  clock; all state updates on its falling edge, matching the processor datapath.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only while Busy = 0.
- `ALU_Op`  in  5  operation code, latched with Start.
- `Data_1`  in  WIDTH  signed operand A, latched with Start.
- `Data_2`  in  WIDTH  signed operand B, latched with Start.
- `Busy`  out  1  operation in progress; Start ignored.
- `Done`  out  1  one-cycle pulse; Result/flags updated this cycle.
- `Result`  out  WIDTH  signed result, held until next Done.
- `True`  out  1  compare outcome, held with Result.
- `Overflow`  out  1  signed overflow for ADD/SUB/MUL, and for DIV of MIN by −1.
- `Div_Zero`  out  1  DIV/MOD with Data_2 = 0.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD
  - 5 AND, 6 OR, 7 XOR, 8 NOT (Data_1)
  - 9 SHL, 10 SRA (arithmetic)
  - 11 EQ, 12 NE, 13 GE, 14 GT, 15 LE, 16 LT (signed)
  - 17 NOP, 18 IMM (Result = Data_2)
  - 19–31 behave as NOP.
- Compares: Result = 1 and True = 1 if the condition holds, else both 0. True = 0 for all non-compare ops.
- Shifts use only `Data_2[SHIFT_W-1:0]`.
- ADD/SUB Overflow: operand signs agree (SUB: differ) and result sign differs. All other flags are 0 unless defined below.
- MUL: shift-add over magnitudes for WIDTH iterations, 2·WIDTH internal product.
  - Result = low WIDTH bits of the signed product.
  - Overflow = 1 if the product does not fit in WIDTH signed bits.
- DIV/MOD: restoring division on magnitudes for WIDTH iterations.
  - Quotient truncates toward zero; remainder takes the sign of Data_1.
  - MIN / −1: Result = MIN, Overflow = 1; MOD of the same operands gives 0.
- Divide by zero is detected at Start and completes with single-cycle latency:
  - DIV: Result = all ones.
  - MOD: Result = Data_1.
  - Div_Zero = 1.
- State machine (states IDLE, ITER):
  - IDLE + Start with a MUL/DIV/MOD op (non-zero divisor): go to ITER, load the counter with WIDTH.
  - ITER: decrement the counter each edge; at 0, write the outputs, pulse Done, return to IDLE.
  - IDLE + Start with any other op: write the outputs and pulse Done at the next edge, stay in IDLE.
  - IDLE without Start: hold all outputs; Done = 0.
- Reset: state IDLE, counter 0, Busy = Done = Result = True = Overflow = Div_Zero = 0.
- Reset during ITER aborts the operation: no Done, and Result is cleared.

## Timing
- Start is sampled at edge 0 and Done rises at edge L:
  - L = 1 for single-cycle ops and for divide by zero.
  - L = WIDTH + 1 for MUL/DIV/MOD.
- Busy is high from edge 1 to edge L−1 (never for L = 1), and low whenever Done is high.
- Start presented in the Done cycle is accepted, giving back-to-back issue at one op per cycle for single-cycle ops.
- Inputs may change after edge 0; only the latched copies are used.
- Reset and Start in the same cycle: Reset wins.

## Structure
- Package `alu_pkg`:
  - 5-bit op-code localparams (OP_ADD … OP_IMM).
  - FSM state enum {IDLE, ITER}.
  - Helper function `is_multicycle(op)`.
- Sub-module `seq_divider` (magnitude restoring divider, WIDTH-parametrised):
  - Ports: load, dividend, divisor, step; outputs quotient, remainder.
  - The multiply shift-add stays inline: one adder plus the shared counter.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 1 -> at L=1: Result 0x80000000, Overflow 1, Done one cycle, Busy never high.
- MUL −7 × 6 -> Busy 32 cycles, Done at edge 33, Result −42, Overflow 0. Then MUL 0x10000 × 0x10000 -> Result 0, Overflow 1.
- DIV −17 / 5 -> Result −3; MOD −17 % 5 -> Result −2. DIV MIN / −1 -> Result MIN, Overflow 1.
- DIV 9 / 0 -> L=1: Result 0xFFFFFFFF, Div_Zero 1. MOD 9 % 0 -> Result 9.
- Start MUL, pulse Start again with ADD during Busy (ignored), assert Reset at iteration 10 -> no Done, all outputs 0. Next ADD 2+3 -> Result 5 at L=1.
- WIDTH=8: LT −1 < 1 -> Result 1, True 1. SRA 0x80 by Data_2=0x0B (uses 3 bits -> 3) -> Result 0xF0. Back-to-back EQ issued in the Done cycle -> accepted.
